// File: rtl/calc2_pkg.sv
// Shared types and arithmetic for the calc2 four-port tagged calculator.
package calc2_pkg;
  localparam int DATA_W     = 32;
  localparam int TAG_W      = 2;
  localparam int CMD_W      = 4;
  localparam int NPORTS     = 4;
  localparam int FIFO_DEPTH = 4;

  typedef enum logic [CMD_W-1:0] {
    NOP = 4'd0, ADD = 4'd1, SUB = 4'd2, SHL = 4'd5, SHR = 4'd6
  } cmd_e;

  typedef enum logic [1:0] {
    NONE = 2'd0, OK = 2'd1, OVF = 2'd2, INV = 2'd3
  } resp_e;

  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
  } req_t;

  typedef struct packed {
    logic [1:0]        resp;
    logic [DATA_W-1:0] data;
  } res_t;

  function automatic logic is_addsub(input logic [CMD_W-1:0] c);
    return (c == ADD) || (c == SUB);
  endfunction

  function automatic logic is_shift(input logic [CMD_W-1:0] c);
    return (c == SHL) || (c == SHR);
  endfunction

  // Unsigned arithmetic; any wrap (carry or borrow) is reported as OVF with zero data.
  function automatic res_t calc(input req_t r);
    res_t             o;
    logic [DATA_W:0]  sum;
    o.resp = INV;
    o.data = '0;
    sum    = {1'b0, r.op1} + {1'b0, r.op2};
    case (r.cmd)
      ADD: begin
        o.resp = sum[DATA_W] ? OVF : OK;
        o.data = sum[DATA_W] ? '0 : sum[DATA_W-1:0];
      end
      SUB: begin
        o.resp = (r.op2 > r.op1) ? OVF : OK;
        o.data = (r.op2 > r.op1) ? '0 : r.op1 - r.op2;
      end
      SHL: begin
        o.resp = OK;
        o.data = r.op1 << r.op2[4:0];
      end
      SHR: begin
        o.resp = OK;
        o.data = r.op1 >> r.op2[4:0];
      end
      default: ;
    endcase
    return o;
  endfunction
endpackage

// File: rtl/calc2_if.sv
// Request/response bundle for all four calc2 ports; master = host, slave = core.
interface calc2_if;
  import calc2_pkg::*;
  logic [CMD_W-1:0]  req1_cmd_in,  req2_cmd_in,  req3_cmd_in,  req4_cmd_in;
  logic [DATA_W-1:0] req1_data_in, req2_data_in, req3_data_in, req4_data_in;
  logic [TAG_W-1:0]  req1_tag_in,  req2_tag_in,  req3_tag_in,  req4_tag_in;
  logic [1:0]        out_resp1,    out_resp2,    out_resp3,    out_resp4;
  logic [DATA_W-1:0] out_data1,    out_data2,    out_data3,    out_data4;
  logic [TAG_W-1:0]  out_tag1,     out_tag2,     out_tag3,     out_tag4;

  modport master (
    output req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
    output req1_data_in, req2_data_in, req3_data_in, req4_data_in,
    output req1_tag_in, req2_tag_in, req3_tag_in, req4_tag_in,
    input  out_resp1, out_resp2, out_resp3, out_resp4,
    input  out_data1, out_data2, out_data3, out_data4,
    input  out_tag1, out_tag2, out_tag3, out_tag4
  );

  modport slave (
    input  req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
    input  req1_data_in, req2_data_in, req3_data_in, req4_data_in,
    input  req1_tag_in, req2_tag_in, req3_tag_in, req4_tag_in,
    output out_resp1, out_resp2, out_resp3, out_resp4,
    output out_data1, out_data2, out_data3, out_data4,
    output out_tag1, out_tag2, out_tag3, out_tag4
  );
endinterface

// File: rtl/calc2_port_fifo.sv
// Per-port two-cycle request capture feeding a FIFO_DEPTH-entry request queue.
module calc2_port_fifo
  import calc2_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CMD_W-1:0]  cmd,
  input  logic [TAG_W-1:0]  tag,
  input  logic [DATA_W-1:0] data,
  input  logic              pop,
  output req_t              head,
  output logic              head_vld
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  req_t              mem [FIFO_DEPTH];
  logic              pend;
  logic [CMD_W-1:0]  cap_cmd;
  logic [TAG_W-1:0]  cap_tag;
  logic [DATA_W-1:0] cap_op1;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  logic              full, push;

  assign full     = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign push     = pend && !full;
  assign head     = mem[rd_ptr];
  assign head_vld = (count != '0);

  // The cycle after a command is always the operand2 cycle; its cmd is ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend    <= 1'b0;
      cap_cmd <= '0;
      cap_tag <= '0;
      cap_op1 <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      if (pend) begin
        pend <= 1'b0;
      end else if (cmd != '0) begin
        pend    <= 1'b1;
        cap_cmd <= cmd;
        cap_tag <= tag;
        cap_op1 <= data;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{cmd: cap_cmd, tag: cap_tag, op1: cap_op1, op2: data};
  end
endmodule

// File: rtl/calc2_core.sv
// Four-port tagged calculator: per-port queues, shared add/sub and shift units, fixed-priority dispatch.
module calc2_core
  import calc2_pkg::*;
(
  input logic   c_clk,
  input logic   reset,
  calc2_if.slave bus
);
  logic [NPORTS-1:0][CMD_W-1:0]  cmd;
  logic [NPORTS-1:0][TAG_W-1:0]  tag;
  logic [NPORTS-1:0][DATA_W-1:0] data;
  req_t [NPORTS-1:0]             head;
  res_t [NPORTS-1:0]             res;
  logic [NPORTS-1:0]             head_vld, pop;
  logic [NPORTS-1:0][1:0]        resp_q;
  logic [NPORTS-1:0][DATA_W-1:0] data_q;
  logic [NPORTS-1:0][TAG_W-1:0]  tag_q;

  assign cmd  = {bus.req4_cmd_in,  bus.req3_cmd_in,  bus.req2_cmd_in,  bus.req1_cmd_in};
  assign tag  = {bus.req4_tag_in,  bus.req3_tag_in,  bus.req2_tag_in,  bus.req1_tag_in};
  assign data = {bus.req4_data_in, bus.req3_data_in, bus.req2_data_in, bus.req1_data_in};

  for (genvar g = 0; g < NPORTS; g++) begin : g_port
    calc2_port_fifo u_fifo (
      .clk      (c_clk),
      .rst_n    (reset),
      .cmd      (cmd[g]),
      .tag      (tag[g]),
      .data     (data[g]),
      .pop      (pop[g]),
      .head     (head[g]),
      .head_vld (head_vld[g])
    );
    assign res[g] = calc(head[g]);
  end

  // Lowest port index wins each unit; invalid heads bypass both units.
  always_comb begin : arb
    logic as_busy, sh_busy;
    pop     = '0;
    as_busy = 1'b0;
    sh_busy = 1'b0;
    for (int p = 0; p < NPORTS; p++) begin
      if (head_vld[p]) begin
        if (is_addsub(head[p].cmd)) begin
          if (!as_busy) begin
            pop[p]  = 1'b1;
            as_busy = 1'b1;
          end
        end else if (is_shift(head[p].cmd)) begin
          if (!sh_busy) begin
            pop[p]  = 1'b1;
            sh_busy = 1'b1;
          end
        end else begin
          pop[p] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge c_clk) begin
    if (!reset) begin
      resp_q <= '0;
      data_q <= '0;
      tag_q  <= '0;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        if (pop[p]) begin
          resp_q[p] <= res[p].resp;
          data_q[p] <= res[p].data;
          tag_q[p]  <= head[p].tag;
        end else begin
          resp_q[p] <= NONE;
          data_q[p] <= '0;
          tag_q[p]  <= '0;
        end
      end
    end
  end

  assign bus.out_resp1 = resp_q[0];
  assign bus.out_resp2 = resp_q[1];
  assign bus.out_resp3 = resp_q[2];
  assign bus.out_resp4 = resp_q[3];
  assign bus.out_data1 = data_q[0];
  assign bus.out_data2 = data_q[1];
  assign bus.out_data3 = data_q[2];
  assign bus.out_data4 = data_q[3];
  assign bus.out_tag1  = tag_q[0];
  assign bus.out_tag2  = tag_q[1];
  assign bus.out_tag3  = tag_q[2];
  assign bus.out_tag4  = tag_q[3];
endmodule

// File: tb/tb_calc2_core.sv
// Directed plus random stimulus for calc2_core against a queue-based reference model.
module tb_calc2_core;
  import calc2_pkg::*;

  logic c_clk = 1'b0;
  logic reset = 1'b0;
  always #5 c_clk = ~c_clk;

  calc2_if bus ();
  calc2_core dut (.c_clk(c_clk), .reset(reset), .bus(bus));

  logic [3:0]  d_cmd  [4];
  logic [31:0] d_data [4];
  logic [1:0]  d_tag  [4];
  logic [1:0]  o_resp [4];
  logic [31:0] o_data [4];
  logic [1:0]  o_tag  [4];

  assign bus.req1_cmd_in  = d_cmd[0];
  assign bus.req2_cmd_in  = d_cmd[1];
  assign bus.req3_cmd_in  = d_cmd[2];
  assign bus.req4_cmd_in  = d_cmd[3];
  assign bus.req1_data_in = d_data[0];
  assign bus.req2_data_in = d_data[1];
  assign bus.req3_data_in = d_data[2];
  assign bus.req4_data_in = d_data[3];
  assign bus.req1_tag_in  = d_tag[0];
  assign bus.req2_tag_in  = d_tag[1];
  assign bus.req3_tag_in  = d_tag[2];
  assign bus.req4_tag_in  = d_tag[3];
  assign o_resp[0] = bus.out_resp1;
  assign o_resp[1] = bus.out_resp2;
  assign o_resp[2] = bus.out_resp3;
  assign o_resp[3] = bus.out_resp4;
  assign o_data[0] = bus.out_data1;
  assign o_data[1] = bus.out_data2;
  assign o_data[2] = bus.out_data3;
  assign o_data[3] = bus.out_data4;
  assign o_tag[0]  = bus.out_tag1;
  assign o_tag[1]  = bus.out_tag2;
  assign o_tag[2]  = bus.out_tag3;
  assign o_tag[3]  = bus.out_tag4;

  typedef struct {
    logic [3:0]  cmd;
    logic [1:0]  tag;
    logic [31:0] op1;
    logic [31:0] op2;
  } mreq_t;

  // Reference model state: pending first halves and queued requests per port.
  mreq_t       mq [4][$];
  mreq_t       mcap [4];
  bit          mpend [4];
  logic [1:0]  exp_resp [4];
  logic [31:0] exp_data [4];
  logic [1:0]  exp_tag  [4];

  // Host-side bookkeeping.
  bit [3:0]    tag_busy [4];
  bit          op2_phase [4];
  logic [31:0] op2_hold [4];
  bit          nc_valid [4];
  mreq_t       nc [4];
  bit          rand_mode = 0;
  bit          rst_req = 1;
  bit          chk_en = 0;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic ref_result(input mreq_t r, output logic [1:0] resp, output logic [31:0] data);
    longint unsigned a = r.op1;
    longint unsigned b = r.op2;
    resp = 2'd1;
    data = 32'd0;
    case (r.cmd)
      4'd1: if (a + b > 64'hFFFF_FFFF) resp = 2'd2; else data = 32'(a + b);
      4'd2: if (b > a) resp = 2'd2; else data = 32'(a - b);
      4'd5: data = 32'(a << (b % 32));
      4'd6: data = 32'(a >> (b % 32));
      default: resp = 2'd3;
    endcase
  endtask

  // Advances the model across one clock edge using the inputs held at that edge.
  task automatic model_step();
    int sz [4];
    bit add_used = 0;
    bit sh_used = 0;
    if (!reset) begin
      for (int p = 0; p < 4; p++) begin
        mq[p].delete();
        mpend[p] = 0;
        exp_resp[p] = 0; exp_data[p] = 0; exp_tag[p] = 0;
        tag_busy[p] = 0;
      end
      return;
    end
    for (int p = 0; p < 4; p++) begin
      sz[p] = mq[p].size();
      exp_resp[p] = 0; exp_data[p] = 0; exp_tag[p] = 0;
      if (sz[p] > 0) begin
        mreq_t h;
        bit go;
        h = mq[p][0];
        case (h.cmd)
          4'd1, 4'd2: begin go = !add_used; if (go) add_used = 1; end
          4'd5, 4'd6: begin go = !sh_used;  if (go) sh_used = 1;  end
          default:    go = 1;
        endcase
        if (go) begin
          ref_result(h, exp_resp[p], exp_data[p]);
          exp_tag[p] = h.tag;
          tag_busy[p][h.tag] = 0;
          void'(mq[p].pop_front());
        end
      end
      if (mpend[p]) begin
        mcap[p].op2 = d_data[p];
        if (sz[p] < 4) mq[p].push_back(mcap[p]);
        mpend[p] = 0;
      end else if (d_cmd[p] != 0) begin
        mcap[p].cmd = d_cmd[p];
        mcap[p].tag = d_tag[p];
        mcap[p].op1 = d_data[p];
        mpend[p] = 1;
      end
    end
  endtask

  task automatic issue_now(input int p, input mreq_t r);
    d_cmd[p] = r.cmd;
    d_tag[p] = r.tag;
    d_data[p] = r.op1;
    op2_hold[p] = r.op2;
    op2_phase[p] = 1;
    tag_busy[p][r.tag] = 1;
  endtask

  function automatic logic [31:0] rand_op();
    if ($urandom_range(0, 3) == 0) begin
      case ($urandom_range(0, 3))
        0: return 32'h0;
        1: return 32'h1;
        2: return 32'hFFFF_FFFF;
        default: return 32'h8000_0000;
      endcase
    end
    return $urandom;
  endfunction

  task automatic rand_req(input int p, output mreq_t r);
    int t0 = $urandom_range(0, 3);
    case ($urandom_range(0, 9))
      0, 1: r.cmd = 4'd1;
      2, 3: r.cmd = 4'd2;
      4, 5: r.cmd = 4'd5;
      6, 7: r.cmd = 4'd6;
      8:    r.cmd = 4'd3;
      default: r.cmd = 4'($urandom_range(7, 15));
    endcase
    r.tag = 0;
    for (int i = 0; i < 4; i++) begin
      if (!tag_busy[p][(t0 + i) % 4]) begin
        r.tag = 2'((t0 + i) % 4);
        break;
      end
    end
    r.op1 = rand_op();
    r.op2 = rand_op();
  endtask

  task automatic drive();
    reset = !rst_req;
    for (int p = 0; p < 4; p++) begin
      if (op2_phase[p]) begin
        d_cmd[p] = 0;
        d_data[p] = op2_hold[p];
        d_tag[p] = 2'($urandom);
        op2_phase[p] = 0;
      end else if (!rst_req && nc_valid[p]) begin
        issue_now(p, nc[p]);
        nc_valid[p] = 0;
      end else if (!rst_req && rand_mode && tag_busy[p] != 4'hF && $urandom_range(0, 2) == 0) begin
        mreq_t r;
        rand_req(p, r);
        issue_now(p, r);
      end else begin
        d_cmd[p] = 0;
        d_data[p] = $urandom;
        d_tag[p] = 2'($urandom);
      end
    end
  endtask

  task automatic step();
    @(posedge c_clk);
    #1;
    model_step();
    chk_en = 1;
    drive();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic req(input int p, input logic [3:0] cmd, input logic [1:0] tag,
                     input logic [31:0] op1, input logic [31:0] op2);
    nc[p] = '{cmd: cmd, tag: tag, op1: op1, op2: op2};
    nc_valid[p] = 1;
  endtask

  always @(negedge c_clk) begin
    if (chk_en) begin
      for (int p = 0; p < 4; p++) begin
        tests++;
        if (o_resp[p] !== exp_resp[p] || o_data[p] !== exp_data[p] || o_tag[p] !== exp_tag[p]) begin
          fails++;
          $display("FAIL port%0d outputs @%0t: got resp=%0d data=%h tag=%0d, want resp=%0d data=%h tag=%0d",
                   p + 1, $time, o_resp[p], o_data[p], o_tag[p], exp_resp[p], exp_data[p], exp_tag[p]);
        end
      end
    end
  end

  initial begin
    for (int p = 0; p < 4; p++) begin
      d_cmd[p] = 0; d_data[p] = 0; d_tag[p] = 0;
      op2_phase[p] = 0; nc_valid[p] = 0; tag_busy[p] = 0; mpend[p] = 0;
      exp_resp[p] = 0; exp_data[p] = 0; exp_tag[p] = 0;
    end
    rst_req = 1;
    run(3);
    for (int p = 0; p < 4; p++) check("reset resp", exp_resp[p], 0);
    rst_req = 0;

    // Single add on port 1
    req(0, 4'd1, 2'd0, 32'd5, 32'd7);
    run(4);
    check("t1 resp", exp_resp[0], 1);
    check("t1 data", exp_data[0], 12);
    check("t1 tag", exp_tag[0], 0);
    for (int p = 1; p < 4; p++) check("t1 other port idle", exp_resp[p], 0);
    run(1);
    check("t1 one cycle only", exp_resp[0], 0);
    run(3);

    // Overflow / underflow on port 2
    req(1, 4'd1, 2'd0, 32'hFFFF_FFFF, 32'd1);
    run(4);
    check("t2 add carry resp", exp_resp[1], 2);
    check("t2 add carry data", exp_data[1], 0);
    run(2);
    req(1, 4'd2, 2'd1, 32'd3, 32'd5);
    run(4);
    check("t2 sub borrow resp", exp_resp[1], 2);
    run(2);
    req(1, 4'd2, 2'd2, 32'd5, 32'd3);
    run(4);
    check("t2 sub resp", exp_resp[1], 1);
    check("t2 sub data", exp_data[1], 2);
    run(2);

    // Shifts on port 3
    req(2, 4'd5, 2'd0, 32'd1, 32'd31);
    run(4);
    check("t3 shl data", exp_data[2], 32'h8000_0000);
    run(2);
    req(2, 4'd6, 2'd1, 32'h8000_0000, 32'd36);
    run(4);
    check("t3 shr data", exp_data[2], 32'h0800_0000);
    check("t3 shr resp", exp_resp[2], 1);
    run(2);

    // Invalid command on port 4
    req(3, 4'd3, 2'd2, 32'h1234, 32'h55);
    run(4);
    check("t4 inv resp", exp_resp[3], 3);
    check("t4 inv data", exp_data[3], 0);
    check("t4 inv tag", exp_tag[3], 2);
    run(2);

    // Add unit contention: port 2 loses to port 1 by one cycle
    req(0, 4'd1, 2'd1, 32'd1, 32'd1);
    req(1, 4'd1, 2'd1, 32'd2, 32'd2);
    req(2, 4'd5, 2'd1, 32'd3, 32'd1);
    run(4);
    check("t5 p1 first", exp_resp[0], 1);
    check("t5 p3 shift parallel", exp_resp[2], 1);
    check("t5 p3 data", exp_data[2], 6);
    check("t5 p2 waits", exp_resp[1], 0);
    run(1);
    check("t5 p2 later", exp_resp[1], 1);
    check("t5 p2 data", exp_data[1], 4);
    run(3);

    // Back-to-back port 1 requests stay in order
    for (int k = 0; k < 4; k++) begin
      req(0, 4'd1, 2'(k), 32'(k), 32'd1);
      run(2);
    end
    check("t5b tag2 order", exp_tag[0], 2);
    check("t5b tag2 data", exp_data[0], 3);
    run(2);
    check("t5b tag3 order", exp_tag[0], 3);
    check("t5b tag3 data", exp_data[0], 4);
    run(4);

    // Reset during the operand2 cycle kills the request
    req(0, 4'd1, 2'd1, 32'd10, 32'd20);
    step();
    rst_req = 1;
    run(3);
    rst_req = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      check("t6 no resp after reset", exp_resp[0], 0);
    end
    req(0, 4'd1, 2'd3, 32'd100, 32'd23);
    run(4);
    check("t6 post-reset resp", exp_resp[0], 1);
    check("t6 post-reset data", exp_data[0], 123);
    check("t6 post-reset tag", exp_tag[0], 3);
    run(2);

    // Random traffic on all ports
    rand_mode = 1;
    run(2500);
    rand_mode = 0;
    run(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
